// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: access-size codes
// and FSM state encoding.
package mem_stage_lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus: request side is driven by the LSU (master), the memory
// returns grant, read-valid and read data (slave).
interface mem_stage_lsu_if;

  logic                                req;
  logic                                we;
  logic [3:0]                          be;
  logic [mem_stage_lsu_pkg::XLEN-1:0]  addr;
  logic [mem_stage_lsu_pkg::XLEN-1:0]  wdata;
  logic                                gnt;
  logic                                rvalid;
  logic [mem_stage_lsu_pkg::XLEN-1:0]  rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for stores, lane extraction plus sign/zero extension for
// loads, and the alignment check. Purely combinational.
module lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << off;
        wdata      = {2{store_data[15:0]}};
        misaligned = off[0];
      end
      default: misaligned = (off != 2'b00);
    endcase
  end

  // Misaligned halves never reach the bus, so only the two aligned slots matter
  always_comb begin
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: runs one data-memory access per MEM-stage op
// and stalls the pipeline until it completes.
//
//   state     | meaning
//   ST_IDLE   | no access in flight; an aligned op launches one
//   ST_REQ    | request on the bus, waiting for grant
//   ST_WAIT_R | load granted, waiting for read data
//   ST_DONE   | access complete; stall released for one cycle
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_memread,
  input  logic            mem_memwrite,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_store_data,
  mem_stage_lsu_if.master dmem,
  output logic [XLEN-1:0] mem_read_data,
  output logic            mem_stall,
  output logic            mem_misaligned
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] rdata_q;
  logic            op, is_load, is_store, aligned_op;
  logic            capture, store_gnt;
  logic [3:0]      be_raw;
  logic [XLEN-1:0] wdata_raw, load_data;
  logic            mis_raw;

  assign op       = mem_memread | mem_memwrite;
  assign is_load  = mem_memread;
  assign is_store = mem_memwrite & ~mem_memread;

  lsu_align u_align (
    .funct3     (mem_funct3),
    .off        (mem_alu_result[1:0]),
    .store_data (mem_store_data),
    .rdata      (dmem.rdata),
    .be         (be_raw),
    .wdata      (wdata_raw),
    .load_data  (load_data),
    .misaligned (mis_raw)
  );

  assign aligned_op = op & ~mis_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (aligned_op) state_d = ST_REQ;
      ST_REQ:    if (dmem.gnt) state_d = (is_load & ~dmem.rvalid) ? ST_WAIT_R : ST_DONE;
      ST_WAIT_R: if (dmem.rvalid) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Stores clear the capture register so DONE never replays an older load
  assign capture   = ((state_q == ST_REQ) & dmem.gnt & dmem.rvalid & is_load)
                   | ((state_q == ST_WAIT_R) & dmem.rvalid);
  assign store_gnt = (state_q == ST_REQ) & dmem.gnt & is_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rdata_q <= '0;
    else if (capture)   rdata_q <= load_data;
    else if (store_gnt) rdata_q <= '0;
  end

  always_comb begin
    dmem.req       = (state_q == ST_REQ);
    dmem.we        = dmem.req & is_store;
    dmem.be        = (dmem.req & is_store) ? be_raw : 4'h0;
    dmem.wdata     = (dmem.req & is_store) ? wdata_raw : '0;
    dmem.addr      = dmem.req ? {mem_alu_result[XLEN-1:2], 2'b00} : '0;
    mem_stall      = aligned_op & (state_q != ST_DONE);
    mem_misaligned = op & mis_raw;
    mem_read_data  = (state_q == ST_DONE) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed and randomized checks of mem_stage_lsu against a behavioural
// model of lane steering, extension and handshake timing.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_memread, mem_memwrite;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_store_data;
  logic [31:0] mem_read_data;
  logic        mem_stall, mem_misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_lsu_if dmem ();

  mem_stage_lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_store_data (mem_store_data),
    .dmem           (dmem),
    .mem_read_data  (mem_read_data),
    .mem_stall      (mem_stall),
    .mem_misaligned (mem_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes, and the value a load must return
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    int          n;
    logic [31:0] mask, v;
    n = nbytes(f3);
    if (n == 4) return rd;
    mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v    = (rd >> (8 * off)) & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int n;
    n = nbytes(f3);
    if (n == 1) return 32'(sd[7:0]) * 32'h0101_0101;
    if (n == 2) return 32'(sd[15:0]) * 32'h0001_0001;
    return sd;
  endfunction

  task automatic idle_inputs();
    mem_memread  = 1'b0;
    mem_memwrite = 1'b0;
    dmem.gnt     = 1'b0;
    dmem.rvalid  = 1'b0;
  endtask

  // Called just after a rising edge with the DUT in IDLE; leaves it in IDLE.
  task automatic do_access(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                           input int gd, input int rvd);
    bit          is_st, mis;
    int          n, off;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    is_st = st && !ld;
    n     = nbytes(f3);
    off   = int'(a[1:0]);
    mis   = (off % n) != 0;
    ebe   = is_st ? 4'(((1 << n) - 1) << off) : 4'h0;
    ewd   = is_st ? model_wdata(f3, sd) : 32'h0;

    mem_memread = ld; mem_memwrite = st; mem_funct3 = f3;
    mem_alu_result = a; mem_store_data = sd;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
    #2;
    chk1("idle_stall", mem_stall, !mis);
    chk1("idle_req", dmem.req, 1'b0);
    chk1("misaligned", mem_misaligned, mis);
    chk32("idle_rdata", mem_read_data, 32'h0);
    if (mis) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        dmem.gnt = 1'($urandom); dmem.rvalid = 1'($urandom); dmem.rdata = $urandom;
        #2;
        chk1("mis_req", dmem.req, 1'b0);
        chk1("mis_stall", mem_stall, 1'b0);
        chk32("mis_rdata", mem_read_data, 32'h0);
      end
      @(posedge clk); #1;
      idle_inputs();
      return;
    end

    @(posedge clk); #1;
    for (int g = 0; g <= gd; g++) begin
      dmem.gnt = (g == gd);
      if (g == gd) begin
        dmem.rvalid = ld && (rvd == 0);
        dmem.rdata  = dmem.rvalid ? rd : $urandom;
      end else begin
        dmem.rvalid = 1'($urandom);
        dmem.rdata  = $urandom;
      end
      #2;
      chk1("req", dmem.req, 1'b1);
      chk1("we", dmem.we, is_st);
      chk32("be", 32'(dmem.be), 32'(ebe));
      chk32("addr", dmem.addr, a & 32'hFFFF_FFFC);
      chk32("wdata", dmem.wdata, ewd);
      chk1("req_stall", mem_stall, 1'b1);
      chk32("req_rdata", mem_read_data, 32'h0);
      @(posedge clk); #1;
    end
    if (ld) begin
      for (int k = 1; k <= rvd; k++) begin
        dmem.gnt    = 1'($urandom);
        dmem.rvalid = (k == rvd);
        dmem.rdata  = (k == rvd) ? rd : $urandom;
        #2;
        chk1("wait_req", dmem.req, 1'b0);
        chk1("wait_stall", mem_stall, 1'b1);
        chk32("wait_rdata", mem_read_data, 32'h0);
        @(posedge clk); #1;
      end
    end
    dmem.gnt = 1'($urandom); dmem.rvalid = 1'($urandom); dmem.rdata = $urandom;
    #2;
    chk1("done_stall", mem_stall, 1'b0);
    chk1("done_req", dmem.req, 1'b0);
    chk32("done_be", 32'(dmem.be), 32'h0);
    if (ld) chk32("done_data", mem_read_data, model_load(f3, off, rd));
    @(posedge clk); #1;
    idle_inputs();
    #2;
    chk1("post_stall", mem_stall, 1'b0);
    chk1("post_req", dmem.req, 1'b0);
    chk32("post_rdata", mem_read_data, 32'h0);
  endtask

  logic [2:0] ld_codes [5];
  logic [2:0] st_codes [3];

  initial begin
    ld_codes = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    st_codes = '{F3_B, F3_H, F3_W};
    rst_n = 1'b0;
    mem_funct3 = F3_W; mem_alu_result = 32'h0; mem_store_data = 32'h0;
    dmem.rdata = 32'h0;
    idle_inputs();
    #2;
    chk1("rst_req", dmem.req, 1'b0);
    chk1("rst_we", dmem.we, 1'b0);
    chk32("rst_be", 32'(dmem.be), 32'h0);
    chk32("rst_addr", dmem.addr, 32'h0);
    chk32("rst_wdata", dmem.wdata, 32'h0);
    chk32("rst_rdata", mem_read_data, 32'h0);
    chk1("rst_stall", mem_stall, 1'b0);
    chk1("rst_mis", mem_misaligned, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_access(1, 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    do_access(1, 0, F3_B, 32'h103, 32'h0, 32'h80123456, 0, 0);
    do_access(1, 0, F3_BU, 32'h103, 32'h0, 32'h80123456, 1, 1);
    do_access(0, 1, F3_H, 32'h22, 32'h0000ABCD, 32'h0, 0, 0);
    do_access(1, 0, F3_W, 32'h101, 32'h0, 32'h0, 0, 0);
    do_access(1, 0, F3_H, 32'h40, 32'h0, 32'h1234F00D, 3, 2);
    do_access(1, 1, F3_HU, 32'h42, 32'h55AA55AA, 32'h8001FFFF, 0, 1);
    do_access(0, 1, F3_W, 32'h302, 32'h11223344, 32'h0, 0, 0);

    // Reset while a load waits for data; a stale rvalid afterwards must be ignored
    mem_memread = 1'b1; mem_memwrite = 1'b0; mem_funct3 = F3_W; mem_alu_result = 32'h200;
    @(posedge clk); #1;
    dmem.gnt = 1'b1;
    @(posedge clk); #1;
    dmem.gnt = 1'b0;
    #2;
    chk1("wr_stall", mem_stall, 1'b1);
    #1;
    rst_n = 1'b0; mem_memread = 1'b0;
    #1;
    chk1("arst_req", dmem.req, 1'b0);
    chk32("arst_addr", dmem.addr, 32'h0);
    chk32("arst_rdata", mem_read_data, 32'h0);
    chk1("arst_stall", mem_stall, 1'b0);
    chk1("arst_mis", mem_misaligned, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dmem.rvalid = 1'b1; dmem.rdata = 32'hBADBAD00;
    #2;
    chk32("late_rv_rdata", mem_read_data, 32'h0);
    chk1("late_rv_req", dmem.req, 1'b0);
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    #2;
    chk32("late_rv_done", mem_read_data, 32'h0);
    chk1("late_rv_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    do_access(1, 0, F3_W, 32'h204, 32'h0, 32'hCAFEF00D, 0, 0);

    for (int t = 0; t < 60; t++) begin
      int          kind;
      logic [2:0]  f3;
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        f3 = ld_codes[$urandom_range(0, 4)];
        do_access(1, 0, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      end else if (kind < 9) begin
        f3 = st_codes[$urandom_range(0, 2)];
        do_access(0, 1, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3), 0);
      end else begin
        f3 = ld_codes[$urandom_range(0, 4)];
        do_access(1, 1, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
